// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: signed or unsigned WIDTH-bit quotient and
// remainder, one quotient bit per cycle, with divide-by-zero flagging.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz_pending;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_dividend_neg;
  logic             w_divisor_neg;
  logic [WIDTH-1:0] w_abs_dividend;
  logic [WIDTH-1:0] w_abs_divisor;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  assign w_dividend_neg = i_signed_op & i_dividend[WIDTH-1];
  assign w_divisor_neg  = i_signed_op & i_divisor[WIDTH-1];

  // Magnitudes are treated as unsigned, so -2^(WIDTH-1) negates to 2^(WIDTH-1) exactly.
  assign w_abs_dividend = w_dividend_neg ? -i_dividend : i_dividend;
  assign w_abs_divisor  = w_divisor_neg  ? -i_divisor  : i_divisor;

  // The remainder is always below the divisor, so WIDTH+1 bits hold the shifted value
  // and the MSB of the trial difference is a reliable borrow.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  // NOTE: datapath registers are reset too, so an aborted divide leaves no stale state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dbz_pending <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
            if (i_divisor == '0) begin
              r_quo         <= '1;
              r_rem         <= i_dividend;
              r_sign_q      <= 1'b0;
              r_sign_r      <= 1'b0;
              r_dbz_pending <= 1'b1;
              r_state       <= S_FINISH;
            end else begin
              r_quo         <= w_abs_dividend;
              r_div         <= w_abs_divisor;
              r_rem         <= '0;
              r_sign_q      <= w_dividend_neg ^ w_divisor_neg;
              r_sign_r      <= w_dividend_neg;
              r_dbz_pending <= 1'b0;
              r_count       <= CW'(WIDTH);
              r_state       <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_quotient    <= r_sign_q ? -r_quo : r_quo;
          r_remainder   <= r_sign_r ? -r_rem : r_rem;
          r_div_by_zero <= r_dbz_pending;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule
